// File: rtl/score_keeper.sv
// Game score engine: scales movement ticks into packed-BCD points, tracks the
// IDLE/RUN/OVER phase, saturates at 9999 and keeps the session high score.
module score_keeper #(
    parameter int TICKS_PER_POINT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_en,
    input  logic        start,
    input  logic        collide,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic        new_hi,
    output logic        saturated,
    output logic [1:0]  phase
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam logic [7:0]  PRE_LAST = 8'(TICKS_PER_POINT - 1);
    localparam logic [15:0] BCD_MAX  = 16'h9999;

    logic [7:0] prescaler;

    // Ripple carry across the four BCD digits; the caller never passes 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= ST_IDLE;
            score     <= '0;
            hi_score  <= '0;
            new_hi    <= 1'b0;
            saturated <= 1'b0;
            prescaler <= '0;
        end else begin
            case (phase)
                ST_IDLE: begin
                    if (start) begin
                        phase     <= ST_RUN;
                        score     <= '0;
                        prescaler <= '0;
                        saturated <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        score     <= '0;
                        prescaler <= '0;
                        saturated <= 1'b0;
                    end else if (collide) begin
                        // Any tick in the collision cycle is dropped.
                        phase <= ST_OVER;
                        if (score > hi_score) begin
                            hi_score <= score;
                            new_hi   <= 1'b1;
                        end
                    end else if (tick_en) begin
                        if (prescaler == PRE_LAST) begin
                            prescaler <= '0;
                            if (score == BCD_MAX) begin
                                saturated <= 1'b1;
                            end else begin
                                score <= bcd_inc(score);
                            end
                        end else begin
                            prescaler <= prescaler + 8'd1;
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        phase     <= ST_RUN;
                        score     <= '0;
                        prescaler <= '0;
                        saturated <= 1'b0;
                        new_hi    <= 1'b0;
                    end
                end
                default: begin
                    phase <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed stimulus pushes expected outputs into a
// queue; a negedge monitor pops and compares them against the DUT.
module tb_score_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default scaling (8 ticks per point)
    logic        rst_a = 1'b0, tick_a = 1'b0, start_a = 1'b0, col_a = 1'b0;
    logic [15:0] score_a, hi_a;
    logic        nh_a, sat_a;
    logic [1:0]  ph_a;

    // Instance B: one tick per point, used to reach 9999 quickly
    logic        rst_b = 1'b0, tick_b = 1'b0, start_b = 1'b0, col_b = 1'b0;
    logic [15:0] score_b, hi_b;
    logic        nh_b, sat_b;
    logic [1:0]  ph_b;

    score_keeper #(.TICKS_PER_POINT(8)) dut_a (
        .clk(clk), .rst(rst_a), .tick_en(tick_a), .start(start_a), .collide(col_a),
        .score(score_a), .hi_score(hi_a), .new_hi(nh_a), .saturated(sat_a), .phase(ph_a)
    );

    score_keeper #(.TICKS_PER_POINT(1)) dut_b (
        .clk(clk), .rst(rst_b), .tick_en(tick_b), .start(start_b), .collide(col_b),
        .score(score_b), .hi_score(hi_b), .new_hi(nh_b), .saturated(sat_b), .phase(ph_b)
    );

    typedef struct {
        int          cyc;
        bit          which;
        string       name;
        logic [15:0] sc;
        logic [15:0] hi;
        logic        nh;
        logic        sat;
        logic [1:0]  ph;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp(string name, string field, logic [15:0] act, logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s %s: got %h want %h", name, field, act, want);
        end
    endfunction

    // Monitor: compare every expectation that is due this cycle
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.which == 1'b0) begin
                cmp(e.name, "score",     score_a,        e.sc);
                cmp(e.name, "hi_score",  hi_a,           e.hi);
                cmp(e.name, "new_hi",    {15'd0, nh_a},  {15'd0, e.nh});
                cmp(e.name, "saturated", {15'd0, sat_a}, {15'd0, e.sat});
                cmp(e.name, "phase",     {14'd0, ph_a},  {14'd0, e.ph});
            end else begin
                cmp(e.name, "score",     score_b,        e.sc);
                cmp(e.name, "hi_score",  hi_b,           e.hi);
                cmp(e.name, "new_hi",    {15'd0, nh_b},  {15'd0, e.nh});
                cmp(e.name, "saturated", {15'd0, sat_b}, {15'd0, e.sat});
                cmp(e.name, "phase",     {14'd0, ph_b},  {14'd0, e.ph});
            end
        end
    end

    task automatic expect_out(input bit w, input string name, input logic [15:0] sc,
                              input logic [15:0] hi, input logic nh, input logic sat,
                              input logic [1:0] ph);
        exp_t e;
        e.cyc = cyc; e.which = w; e.name = name;
        e.sc = sc; e.hi = hi; e.nh = nh; e.sat = sat; e.ph = ph;
        q.push_back(e);
    endtask

    // Apply inputs for one cycle; outputs are sampled after the edge
    task automatic step(input bit w, input bit t, input bit s, input bit c, input bit r);
        if (w == 1'b0) begin
            tick_a = t; start_a = s; col_a = c; rst_a = r;
        end else begin
            tick_b = t; start_b = s; col_b = c; rst_b = r;
        end
        @(posedge clk);
        #1;
        tick_a = 0; start_a = 0; col_a = 0; rst_a = 0;
        tick_b = 0; start_b = 0; col_b = 0; rst_b = 0;
    endtask

    task automatic ticks(input bit w, input int n);
        for (int i = 0; i < n; i++) step(w, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        step(0, 1, 1, 1, 1);
        expect_out(0, "reset_a", 16'h0000, 16'h0000, 0, 0, 2'b00);
        step(0, 1, 0, 1, 0);
        expect_out(0, "idle_ignore", 16'h0000, 16'h0000, 0, 0, 2'b00);

        // 1: 24 ticks give 3 points
        step(0, 0, 1, 0, 0);
        expect_out(0, "start_idle", 16'h0000, 16'h0000, 0, 0, 2'b01);
        ticks(0, 23);
        expect_out(0, "ticks_23", 16'h0002, 16'h0000, 0, 0, 2'b01);
        ticks(0, 1);
        expect_out(0, "ticks_24", 16'h0003, 16'h0000, 0, 0, 2'b01);

        // 2: 0099 -> 0100 double carry
        step(0, 0, 1, 0, 0);
        expect_out(0, "restart_run", 16'h0000, 16'h0000, 0, 0, 2'b01);
        ticks(0, 99 * 8);
        expect_out(0, "score_0099", 16'h0099, 16'h0000, 0, 0, 2'b01);
        ticks(0, 7);
        expect_out(0, "pre_carry", 16'h0099, 16'h0000, 0, 0, 2'b01);
        ticks(0, 1);
        expect_out(0, "carry_0100", 16'h0100, 16'h0000, 0, 0, 2'b01);

        // 4: collide with the 8th tick, new high score
        step(0, 0, 1, 0, 0);
        ticks(0, 42 * 8 + 7);
        expect_out(0, "score_0042", 16'h0042, 16'h0000, 0, 0, 2'b01);
        step(0, 1, 0, 1, 0);
        expect_out(0, "collide_hi", 16'h0042, 16'h0042, 1, 0, 2'b10);
        step(0, 1, 0, 1, 0);
        expect_out(0, "over_ignore", 16'h0042, 16'h0042, 1, 0, 2'b10);

        // 5: lower score does not beat the high score
        step(0, 0, 1, 0, 0);
        expect_out(0, "start_over", 16'h0000, 16'h0042, 0, 0, 2'b01);
        ticks(0, 17 * 8);
        step(0, 0, 0, 1, 0);
        expect_out(0, "collide_low", 16'h0017, 16'h0042, 0, 0, 2'b10);
        step(0, 0, 1, 0, 0);
        expect_out(0, "start_over2", 16'h0000, 16'h0042, 0, 0, 2'b01);

        // 6: start beats collide; reset mid-game clears everything
        ticks(0, 8);
        expect_out(0, "pre_restart", 16'h0001, 16'h0042, 0, 0, 2'b01);
        step(0, 1, 1, 1, 0);
        expect_out(0, "start_collide", 16'h0000, 16'h0042, 0, 0, 2'b01);
        ticks(0, 16);
        step(0, 1, 0, 0, 1);
        expect_out(0, "rst_mid_run", 16'h0000, 16'h0000, 0, 0, 2'b00);

        // 3: saturation on the one-tick-per-point instance
        step(1, 0, 0, 0, 1);
        expect_out(1, "reset_b", 16'h0000, 16'h0000, 0, 0, 2'b00);
        step(1, 0, 1, 0, 0);
        ticks(1, 10);
        expect_out(1, "b_0010", 16'h0010, 16'h0000, 0, 0, 2'b01);
        ticks(1, 9989);
        expect_out(1, "b_9999", 16'h9999, 16'h0000, 0, 0, 2'b01);
        ticks(1, 16);
        expect_out(1, "b_saturated", 16'h9999, 16'h0000, 0, 1, 2'b01);
        step(1, 0, 0, 1, 0);
        expect_out(1, "b_collide_sat", 16'h9999, 16'h9999, 1, 1, 2'b10);
        step(1, 0, 1, 0, 0);
        expect_out(1, "b_start_clear", 16'h0000, 16'h9999, 0, 0, 2'b01);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
